// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 custom-instruction driver.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HIGH,
        EN_LOW,
        EXEC,
        DONE
    } state_t;

    localparam int FLG_RS     = 0;
    localparam int FLG_LONG   = 1;
    localparam int FLG_NIBBLE = 2;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Return-home ignores bit 0, so 0x02 and 0x03 both need the long wait.
    function automatic logic needs_long_exec(input logic [7:0] cmd);
        return (cmd == CMD_CLEAR) || (cmd[7:1] == CMD_HOME[7:1]);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter that stops at zero; paces every timed LCD phase.
module lcd_delay_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clk_en) begin
            if (load) begin
                count_q <= load_val;
            end else if (count_q != '0) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/lcd_ci_driver.sv
// Multi-cycle Nios II custom instruction that writes one command/data byte to
// an HD44780-class LCD over an 8-bit or 4-bit bus.
module lcd_ci_driver
    import lcd_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int T_SETUP     = 2,
    parameter int T_EN_HIGH   = 25,
    parameter int T_EN_LOW    = 25,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int CNT_W       = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic                 start,
    input  logic [31:0]          dataa,
    input  logic [31:0]          datab,
    output logic [31:0]          result,
    output logic                 done,
    output logic                 rs,
    output logic                 rw,
    output logic                 en,
    output logic [BUS_WIDTH-1:0] db
);

    if (BUS_WIDTH != 8 && BUS_WIDTH != 4) begin : g_bad_bus_width
        $error("lcd_ci_driver: BUS_WIDTH must be 8 or 4");
    end
    if (T_EXEC_LONG - 1 >= (1 << CNT_W) || T_EXEC - 1 >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("lcd_ci_driver: CNT_W too narrow for the execution delays");
    end

    localparam logic [CNT_W-1:0] LD_SETUP     = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN_HIGH   = CNT_W'(T_EN_HIGH - 1);
    localparam logic [CNT_W-1:0] LD_EN_LOW    = CNT_W'(T_EN_LOW - 1);
    localparam logic [CNT_W-1:0] LD_EXEC      = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

    state_t               state_q, state_d;
    logic                 rs_q, rs_d;
    logic [BUS_WIDTH-1:0] db_q, db_d;
    logic [7:0]           byte_q, byte_d;
    logic                 long_q, long_d;
    logic                 second_q, second_d;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_zero;
    logic                 unused_bits;

    assign unused_bits = ^{dataa[31:3], datab[31:8]};

    lcd_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rs_q     <= 1'b0;
            db_q     <= '0;
            byte_q   <= '0;
            long_q   <= 1'b0;
            second_q <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            db_q     <= db_d;
            byte_q   <= byte_d;
            long_q   <= long_d;
            second_q <= second_d;
        end
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        db_d     = db_q;
        byte_d   = byte_q;
        long_d   = long_q;
        second_d = second_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rs_d     = dataa[FLG_RS];
                    byte_d   = datab[7:0];
                    long_d   = dataa[FLG_LONG] | (~dataa[FLG_RS] & needs_long_exec(datab[7:0]));
                    second_d = (BUS_WIDTH == 4) && !dataa[FLG_NIBBLE];
                    // 4-bit mode sends the high nibble first on D7..D4.
                    db_d     = BUS_WIDTH'(datab[7:0] >> (8 - BUS_WIDTH));
                    state_d  = SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d  = EN_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EN_HIGH;
                end
            end
            EN_HIGH: begin
                if (tmr_zero) begin
                    state_d  = EN_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EN_LOW;
                end
            end
            EN_LOW: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (second_q) begin
                        second_d = 1'b0;
                        db_d     = BUS_WIDTH'(byte_q[3:0]);
                        state_d  = SETUP;
                        tmr_val  = LD_SETUP;
                    end else begin
                        state_d  = EXEC;
                        tmr_val  = long_q ? LD_EXEC_LONG : LD_EXEC;
                    end
                end
            end
            EXEC: begin
                if (tmr_zero) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign en     = (state_q == EN_HIGH);
    assign done   = (state_q == DONE);
    assign result = done ? {30'd0, long_q, 1'b1} : 32'd0;
    assign rs     = rs_q;
    assign rw     = 1'b0;
    assign db     = db_q;

endmodule
